mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_arb_rr2.sv | 27 ++
 rtl/mem_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter slice.
//   u1 / u32 / word_t : scalar, 32-bit and 64-bit port types
//   arb_state_t       : transaction FSM state (IDLE, ISSUE, WAIT)
//   owner_t           : which requester owns the transaction (fetch or data)
//   ARB_TIMEOUT_DEFAULT : default grant-to-response limit in cycles
package common;

    typedef logic        u1;
    typedef logic [31:0] u32;
    typedef logic [63:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin picker.
//   valid_i    : fetch requester wants the memory
//   valid_d    : data requester wants the memory
//   last_grant : owner of the most recent grant
//   grant      : one-hot result, bit 0 = fetch, bit 1 = data, 0 when idle
module arb_rr2
    import common::*;
(
    input  u1          valid_i,
    input  u1          valid_d,
    input  owner_t     last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid_i && valid_d) begin
            // Tie: whoever did not win last time goes now.
            grant = (last_grant == OWN_D) ? 2'b01 : 2'b10;
        end else if (valid_i) begin
            grant = 2'b01;
        end else if (valid_d) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory,
// one transaction in flight at a time, with a grant-to-response timeout.
//   clk, reset                 : clock, asynchronous active-high reset
//   ireq_* / iresp_*           : fetch request (32-bit addr) and 32-bit response
//   dreq_* / dresp_*           : data request (addr, we, strobe, wdata) and 64-bit response
//   mreq_* / mresp_*           : shared memory request and its response
//   dbg_state                  : current FSM state, for observation only
//
// Handshake: a request transfers in the cycle where valid and ready are both
// high; the requester keeps valid and its fields stable until then and may
// drop valid earlier to withdraw. mreq follows the same rule with this block
// as the requester. Response valids are single-cycle pulses with no ready.
module mem_arbiter
    import common::*;
#(
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  u1          clk,
    input  u1          reset,
    input  u1          ireq_valid,
    input  u32         ireq_addr,
    output u1          ireq_ready,
    output u1          iresp_valid,
    output u32         iresp_data,
    output u1          iresp_err,
    input  u1          dreq_valid,
    input  u32         dreq_addr,
    input  u1          dreq_we,
    input  logic [7:0] dreq_strobe,
    input  word_t      dreq_wdata,
    output u1          dreq_ready,
    output u1          dresp_valid,
    output word_t      dresp_data,
    output u1          dresp_err,
    output u1          mreq_valid,
    output u32         mreq_addr,
    output u1          mreq_we,
    output logic [7:0] mreq_strobe,
    output word_t      mreq_wdata,
    input  u1          mreq_ready,
    input  u1          mresp_valid,
    input  word_t      mresp_data,
    output arb_state_t dbg_state
);

    // The counter reads k-1 in the k-th cycle after the grant. Firing when it
    // reads TIMEOUT-2 registers the error so that it is visible exactly
    // TIMEOUT cycles after the grant. TIMEOUT must be at least 2.
    localparam u32 FIRE_AT = u32'(TIMEOUT - 32'd2);

    arb_state_t state_q, state_d;
    owner_t     owner_q, owner_d;
    owner_t     last_grant_q, last_grant_d;
    u32         addr_q, addr_d;
    u1          we_q, we_d;
    logic [7:0] strobe_q, strobe_d;
    word_t      wdata_q, wdata_d;
    u32         cnt_q, cnt_d;
    u1          mreq_valid_q, mreq_valid_d;
    u1          iresp_valid_q, iresp_valid_d;
    u32         iresp_data_q, iresp_data_d;
    u1          iresp_err_q, iresp_err_d;
    u1          dresp_valid_q, dresp_valid_d;
    word_t      dresp_data_q, dresp_data_d;
    u1          dresp_err_q, dresp_err_d;

    logic [1:0] grant;
    u1          timeout_hit;
    u1          resp_fire;
    u1          resp_err;

    arb_rr2 u_rr (
        .valid_i    (ireq_valid),
        .valid_d    (dreq_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Readies are only offered while idle and never while reset is held.
    assign ireq_ready = ~reset & (state_q == IDLE) & grant[0];
    assign dreq_ready = ~reset & (state_q == IDLE) & grant[1];

    assign timeout_hit = (cnt_q == FIRE_AT);

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        addr_d        = addr_q;
        we_d          = we_q;
        strobe_d      = strobe_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        mreq_valid_d  = mreq_valid_q;
        iresp_valid_d = 1'b0;
        iresp_data_d  = '0;
        iresp_err_d   = 1'b0;
        dresp_valid_d = 1'b0;
        dresp_data_d  = '0;
        dresp_err_d   = 1'b0;
        resp_fire     = 1'b0;
        resp_err      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    owner_d      = grant[1] ? OWN_D : OWN_I;
                    last_grant_d = grant[1] ? OWN_D : OWN_I;
                    if (grant[1]) begin
                        addr_d   = dreq_addr;
                        we_d     = dreq_we;
                        strobe_d = dreq_strobe;
                        wdata_d  = dreq_wdata;
                    end else begin
                        // Fetches are always plain reads.
                        addr_d   = ireq_addr;
                        we_d     = 1'b0;
                        strobe_d = 8'h00;
                        wdata_d  = '0;
                    end
                    cnt_d        = '0;
                    mreq_valid_d = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 32'd1;
                if (timeout_hit) begin
                    resp_fire    = 1'b1;
                    resp_err     = 1'b1;
                    mreq_valid_d = 1'b0;
                    state_d      = IDLE;
                end else if (mreq_ready) begin
                    mreq_valid_d = 1'b0;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 32'd1;
                // A response arriving on the timeout cycle still completes cleanly.
                if (mresp_valid) begin
                    resp_fire = 1'b1;
                    state_d   = IDLE;
                end else if (timeout_hit) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                mreq_valid_d = 1'b0;
                state_d      = IDLE;
            end
        endcase

        if (resp_fire) begin
            if (owner_q == OWN_I) begin
                iresp_valid_d = 1'b1;
                iresp_err_d   = resp_err;
                if (!resp_err) begin
                    iresp_data_d = addr_q[2] ? mresp_data[63:32] : mresp_data[31:0];
                end
            end else begin
                dresp_valid_d = 1'b1;
                dresp_err_d   = resp_err;
                if (!resp_err) begin
                    dresp_data_d = mresp_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= OWN_I;
            last_grant_q  <= OWN_D;
            addr_q        <= '0;
            we_q          <= 1'b0;
            strobe_q      <= 8'h00;
            wdata_q       <= '0;
            cnt_q         <= '0;
            mreq_valid_q  <= 1'b0;
            iresp_valid_q <= 1'b0;
            iresp_data_q  <= '0;
            iresp_err_q   <= 1'b0;
            dresp_valid_q <= 1'b0;
            dresp_data_q  <= '0;
            dresp_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            strobe_q      <= strobe_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            mreq_valid_q  <= mreq_valid_d;
            iresp_valid_q <= iresp_valid_d;
            iresp_data_q  <= iresp_data_d;
            iresp_err_q   <= iresp_err_d;
            dresp_valid_q <= dresp_valid_d;
            dresp_data_q  <= dresp_data_d;
            dresp_err_q   <= dresp_err_d;
        end
    end

    assign mreq_valid  = mreq_valid_q;
    assign mreq_addr   = addr_q;
    assign mreq_we     = we_q;
    assign mreq_strobe = strobe_q;
    assign mreq_wdata  = wdata_q;
    assign iresp_valid = iresp_valid_q;
    assign iresp_data  = iresp_data_q;
    assign iresp_err   = iresp_err_q;
    assign dresp_valid = dresp_valid_q;
    assign dresp_data  = dresp_data_q;
    assign dresp_err   = dresp_err_q;
    assign dbg_state   = state_q;

endmodule
